// File: rtl/decode_pkg.sv
// Shared types and encodings for the buffered RV32IM decode stage.
// ctrl_t is the registered control bundle handed to execute.
package decode_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_B = 3'd1;
    localparam logic [2:0] IMM_S = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] DEST_ALU = 2'd0;
    localparam logic [1:0] DEST_MEM = 2'd1;
    localparam logic [1:0] DEST_PC4 = 2'd3;

    typedef struct packed {
        logic       reg_write;
        logic [3:0] alu_ctrl;
        logic       alu_src;
        logic [2:0] imm_src;
        logic       branch;
        logic       jump;
        logic [1:0] dest_src;
        logic [2:0] mem_ctrl;
        logic       mem_write;
        logic       ui_ctl;
        logic       rd1_ctl;
        logic       pc_rd1_ctl;
        logic       four_imm_ctl;
        logic       mul_sel;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I(M) decoder: instruction word -> ctrl_t.
// M-extension multiply decode is enabled by defining MUL_EXT_EN.
module instr_decoder
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;
    ctrl_t      c;
    logic       unused_fields;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        c              = '0;
        legal          = 1'b1;
        c.mem_ctrl     = f3;
        c.ui_ctl       = 1'b1;
        c.rd1_ctl      = 1'b1;
        c.pc_rd1_ctl   = 1'b1;
        c.four_imm_ctl = 1'b1;
        case (opc)
            OPC_R: begin
                c.reg_write = 1'b1;
                if (f7 == 7'b0000000)
                    c.alu_ctrl = {1'b0, f3};
                else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                    c.alu_ctrl = {1'b1, f3};
`ifdef MUL_EXT_EN
                else if (f7 == 7'b0000001) begin
                    c.mul_sel  = 1'b1;
                    c.alu_ctrl = {1'b0, f3};
                end
`endif
                else
                    legal = 1'b0;
            end
            OPC_I_ALU: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_ctrl  = {(f3 == 3'b101) ? instr[30] : 1'b0, f3};
            end
            OPC_LOAD: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.dest_src  = DEST_MEM;
            end
            OPC_STORE: begin
                c.alu_src   = 1'b1;
                c.imm_src   = IMM_S;
                c.mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                c.branch   = 1'b1;
                c.imm_src  = IMM_B;
                c.alu_ctrl = {1'b0, f3};
            end
            OPC_LUI, OPC_AUIPC: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.imm_src   = IMM_U;
                c.rd1_ctl   = 1'b0;
                c.ui_ctl    = (opc != OPC_LUI);
            end
            OPC_JAL, OPC_JALR: begin
                c.reg_write    = 1'b1;
                c.alu_src      = 1'b1;
                c.jump         = 1'b1;
                c.dest_src     = DEST_PC4;
                c.rd1_ctl      = 1'b0;
                c.four_imm_ctl = 1'b0;
                c.imm_src      = (opc == OPC_JAL) ? IMM_J : IMM_I;
                c.pc_rd1_ctl   = (opc != OPC_JALR);
            end
            default: legal = 1'b0;
        endcase

        // Illegal words carry no side-effecting control, only the operand-select defaults.
        ctrl = c;
        if (!legal) begin
            ctrl              = '0;
            ctrl.illegal      = 1'b1;
            ctrl.ui_ctl       = c.ui_ctl;
            ctrl.rd1_ctl      = c.rd1_ctl;
            ctrl.pc_rd1_ctl   = c.pc_rd1_ctl;
            ctrl.four_imm_ctl = c.four_imm_ctl;
        end
    end

endmodule

// File: rtl/decode_queue_stage.sv
// Buffered decode stage: {pc, instr} FIFO, decoder on the FIFO head, registered output slot.
// Optional multiply decode via MUL_EXT_EN (see instr_decoder).
module decode_queue_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [31:0]                in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [31:0]                out_instr,
    output ctrl_t                      out_ctrl,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // state | meaning
    // RUN   | head entries decode into the slot as it frees up
    // HALT  | illegal instruction reached the slot; pops stop until flush
    typedef enum logic {RUN, HALT} state_t;

    state_t          state;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [31:0]     mem_instr [DEPTH];
    logic            push, load;
    ctrl_t           head_ctrl;

    // Full FIFO refuses a push even if it pops the same cycle: keeps in_ready off out_ready.
    assign in_ready = (count != CW'(DEPTH));
    assign push     = in_valid && in_ready && !flush;
    assign load     = (state == RUN) && (count != '0) && (!out_valid || out_ready) && !flush;
    assign level    = count;
    assign halted   = (state == HALT);

    instr_decoder u_dec (
        .instr (mem_instr[rd_ptr]),
        .ctrl  (head_ctrl)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= in_pc;
            mem_instr[wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_instr <= '0;
            out_ctrl  <= '0;
        end else if (flush) begin
            state     <= RUN;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (load)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(load);
            if (load) begin
                out_valid <= 1'b1;
                out_pc    <= mem_pc[rd_ptr];
                out_instr <= mem_instr[rd_ptr];
                out_ctrl  <= head_ctrl;
                if (head_ctrl.illegal)
                    state <= HALT;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_queue_stage.sv
// Scoreboard bench for decode_queue_stage: directed scenarios followed by random traffic.
// Define MUL_EXT_EN for both RTL and bench to exercise the multiply decode.
module tb_decode_queue_stage;
    import decode_pkg::*;

    localparam int DEPTH = 4;
`ifdef MUL_EXT_EN
    localparam bit MUL = 1'b1;
`else
    localparam bit MUL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    ctrl_t       out_ctrl;
    logic [2:0]  level;
    logic        halted;

    decode_queue_stage #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ctrl  (out_ctrl),
        .level     (level),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        ctrl_t       ctrl;
    } exp_t;

    exp_t        sb[$];     // everything accepted and not yet handed to execute, in order
    logic [31:0] mfifo[$];  // instructions still waiting behind the slot
    bit          m_sv, m_halt;
    int          n_checks = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode, written from the instruction-class table.
    function automatic ctrl_t ref_decode(input logic [31:0] i);
        ctrl_t c, z;
        logic [6:0] op = i[6:0];
        logic [2:0] f3 = i[14:12];
        logic [6:0] f7 = i[31:25];
        bit ok = 1'b1;
        c = '0;
        c.mem_ctrl     = f3;
        c.ui_ctl       = (op != 7'h37);
        c.rd1_ctl      = !(op == 7'h37 || op == 7'h17 || op == 7'h6f || op == 7'h67);
        c.pc_rd1_ctl   = (op != 7'h67);
        c.four_imm_ctl = !(op == 7'h6f || op == 7'h67);
        case (op)
            7'h33: begin
                c.reg_write = 1'b1;
                if (f7 == 7'h00) c.alu_ctrl = {1'b0, f3};
                else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) c.alu_ctrl = {1'b1, f3};
                else if (f7 == 7'h01 && MUL) begin c.mul_sel = 1'b1; c.alu_ctrl = {1'b0, f3}; end
                else ok = 1'b0;
            end
            7'h13: begin c.reg_write = 1; c.alu_src = 1; c.alu_ctrl = {(f3 == 3'd5) ? i[30] : 1'b0, f3}; end
            7'h03: begin c.reg_write = 1; c.alu_src = 1; c.dest_src = 2'd1; end
            7'h23: begin c.alu_src = 1; c.imm_src = 3'd2; c.mem_write = 1; end
            7'h63: begin c.branch = 1; c.imm_src = 3'd1; c.alu_ctrl = {1'b0, f3}; end
            7'h37, 7'h17: begin c.reg_write = 1; c.alu_src = 1; c.imm_src = 3'd3; end
            7'h6f: begin c.reg_write = 1; c.alu_src = 1; c.jump = 1; c.dest_src = 2'd3; c.imm_src = 3'd4; end
            7'h67: begin c.reg_write = 1; c.alu_src = 1; c.jump = 1; c.dest_src = 2'd3; end
            default: ok = 1'b0;
        endcase
        if (ok) return c;
        z = '0;
        z.illegal      = 1'b1;
        z.ui_ctl       = c.ui_ctl;
        z.rd1_ctl      = c.rd1_ctl;
        z.pc_rd1_ctl   = c.pc_rd1_ctl;
        z.four_imm_ctl = c.four_imm_ctl;
        return z;
    endfunction

    // Queue-level model of the stage, advanced at each clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            mfifo.delete();
            sb.delete();
            m_sv = 1'b0;
            m_halt = 1'b0;
        end else begin
            bit pop, acc;
            pop = !m_halt && mfifo.size() > 0 && (!m_sv || out_ready);
            acc = in_valid && mfifo.size() < DEPTH;
            if (pop) begin
                logic [31:0] h;
                h = mfifo.pop_front();
                m_sv = 1'b1;
                if (ref_decode(h).illegal) m_halt = 1'b1;
            end else if (m_sv && out_ready) begin
                m_sv = 1'b0;
            end
            if (acc) begin
                exp_t e;
                e.pc = in_pc; e.instr = in_instr; e.ctrl = ref_decode(in_instr);
                mfifo.push_back(in_instr);
                sb.push_back(e);
            end
        end
    end

    // Monitor: occupancy/status every cycle, payload on every handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("level", level, mfifo.size());
            chk("out_valid", out_valid, m_sv);
            chk("halted", halted, m_halt);
            chk("in_ready", in_ready, mfifo.size() != DEPTH);
            if (out_valid && out_ready && !flush) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 0, 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_pc", out_pc, e.pc);
                    chk("out_instr", out_instr, e.instr);
                    chk("out_ctrl", out_ctrl, e.ctrl);
                end
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic rdy, input logic fl);
        in_valid = v; in_pc = pc; in_instr = ins; out_ready = rdy; flush = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0] ops [10];
        logic [6:0] f7s [4];
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h33};
        f7s = '{7'h00, 7'h20, 7'h01, 7'h00};
        r = $urandom;
        if ($urandom_range(0, 19) == 0) return r;
        r[6:0] = ops[$urandom_range(0, 9)];
        if (r[6:0] == 7'h33 && $urandom_range(0, 9) != 0) r[31:25] = f7s[$urandom_range(0, 3)];
        return r;
    endfunction

    initial begin
        logic [31:0] pc;
        ctrl_t m;
        pc = 32'h1000;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_level", level, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_ctrl", out_ctrl, 0);

        // add x1,x2,x3: visible one edge after the push
        step(1, 32'h100, 32'h003100B3, 1, 0);
        chk("add_not_yet", out_valid, 0);
        step(0, 0, 0, 1, 0);
        chk("add_valid", out_valid, 1);
        chk("add_reg_write", out_ctrl.reg_write, 1);
        chk("add_alu", out_ctrl.alu_ctrl, 0);
        chk("add_dest", out_ctrl.dest_src, 0);
        chk("add_illegal", out_ctrl.illegal, 0);
        step(0, 0, 0, 1, 0);

        // fill with execute stalled, then drain through pointer wrap
        for (int k = 0; k < 6; k++) step(1, pc + 4 * k, 32'h00100093 + (k << 20), 0, 0);
        chk("fill_level", level, 4);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_slot", out_valid, 1);
        for (int k = 0; k < 6; k++) step(0, 0, 0, 1, 0);
        chk("drain_level", level, 0);
        chk("drain_valid", out_valid, 0);

        // illegal word halts the stage, addi stays queued until flush
        step(1, 32'h200, 32'hFFFFFFFF, 1, 0);
        step(1, 32'h204, 32'h00100093, 1, 0);
        chk("ill_flag", out_ctrl.illegal, 1);
        chk("ill_halted", halted, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("halt_hold_level", level, 1);
        chk("halt_hold_valid", out_valid, 0);
        step(0, 0, 0, 1, 1);
        chk("flush_level", level, 0);
        chk("flush_halted", halted, 0);

        // flush beats a simultaneous push and pop
        for (int k = 0; k < 3; k++) step(1, 32'h300 + 4 * k, 32'h00000013, 0, 0);
        chk("pre_flush_level", level, 2);
        step(1, 32'h30C, 32'h00000013, 1, 1);
        chk("flush_pp_level", level, 0);
        chk("flush_pp_valid", out_valid, 0);
        step(0, 0, 0, 1, 0);
        chk("flush_pp_lost", out_valid, 0);

        // mul x1,x2,x3
        step(1, 32'h400, 32'h023100B3, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("mul_sel", out_ctrl.mul_sel, MUL);
        chk("mul_illegal", out_ctrl.illegal, !MUL);
        step(0, 0, 0, 1, 1);

        // jalr x1,0(x5), then async reset mid-stream
        step(1, 32'h500, 32'h000280E7, 1, 0);
        step(0, 0, 0, 0, 0);
        m = out_ctrl;
        chk("jalr_jump", m.jump, 1);
        chk("jalr_dest", m.dest_src, 3);
        chk("jalr_pc_rd1", m.pc_rd1_ctl, 0);
        chk("jalr_rd1", m.rd1_ctl, 0);
        chk("jalr_four", m.four_imm_ctl, 0);
        step(1, 32'h504, 32'h00000013, 0, 0);
        step(1, 32'h508, 32'h00000013, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_level", level, 0);
        chk("arst_pc", out_pc, 0);
        chk("arst_instr", out_instr, 0);
        chk("arst_ctrl", out_ctrl, 0);
        chk("arst_halted", halted, 0);
        in_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            bit fl;
            fl = halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
            step($urandom_range(0, 3) != 0, pc, rand_instr(), $urandom_range(0, 2) != 0, fl);
            pc = pc + 4;
        end
        step(0, 0, 0, 1, 1);
        repeat (3) step(0, 0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
